serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial ripple adder that accepts two WIDTH-bit operands plus carry-in, adds them LSB-first over WIDTH clock cycles with a single one-bit adder cell and a carry flip-flop, and presents the registered sum and carry-out with a one-cycle done pulse. It is the sequential datapath stage that consumes the sum/carry outputs of the team's one-bit adder cells. It trades latency for area in the arithmetic unit.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request an addition; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while an addition is in progress (state SHIFT).
- done  output  1  one-cycle pulse; sum/cout updated this cycle.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered carry-out; held until the next completion.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- IDLE/DONE with start=1: load shift regs sa<=a, sb<=b, carry<=cin, cnt<=0, go SHIFT. With start=0: DONE->IDLE, IDLE holds.
- SHIFT, each cycle: bit s = sa[0]^sb[0]^carry; carry <= majority(sa[0],sb[0],carry); sa, sb shift right (MSB fill 0); partial-sum reg shifts right with s into MSB; cnt++.
- When cnt reaches WIDTH-1 in SHIFT: on that edge, sum <= final partial sum (including last bit), cout <= final carry, go DONE.
- start while busy=1 is ignored; operands a/b/cin are not sampled.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no truncation.
- cnt width = clog2(WIDTH) (min 1). WIDTH=1: SHIFT lasts one cycle.
- Reset (async, any time, including mid-SHIFT): state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal regs 0. Aborted operation produces no done.

## Timing
- Accepted start on edge k -> SHIFT for edges k+1..k+WIDTH -> done=1 in the cycle after edge k+WIDTH; latency WIDTH cycles start-to-done.
- busy = 1 exactly WIDTH cycles per operation; done = 1 exactly one cycle.
- busy and done never high together.
- Back-to-back: start high during the done cycle is accepted; throughput one result per WIDTH+1 cycles.
- sum/cout change only on the edge that raises done; stable otherwise.

## Configuration
- SERIAL_ADDER_OVF_EN defined: ovf port exists; ovf <= carry into MSB XOR carry out of MSB, registered alongside sum/cout, reset 0.
- Undefined: no ovf port, no extra flop; all other behaviour identical.

## Structure
- Package serial_adder_pkg: state typedef (IDLE, SHIFT, DONE) and constant SERIAL_ADDER_DEFAULT_WIDTH = 8.
- Sub-module serial_add_cell: combinational one-bit full add (a, b, cin -> s, c); instantiated once in the top-level block.
- Top-level block holds FSM, counter, operand/partial-sum shift registers, carry flop, result registers.

## Test plan
- Reset: assert reset for 2 cycles mid-SHIFT -> busy=0, done=0, sum=0x00, cout=0 immediately; no done follows.
- WIDTH=8, a=0x03, b=0x05, cin=0, start 1 cycle -> done exactly 8 cycles later, sum=0x08, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
- start re-pulsed with a=0x10, b=0x10 while busy -> ignored; first op's result and done timing unchanged.
- Back-to-back: second start (a=0x01, b=0x02) in done cycle -> sum holds first result for 8 cycles, then sum=0x03 with done.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned SERIAL_ADDER_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/serial_add_cell.sv
// Combinational one-bit full adder used as the serial adder's datapath cell.
module serial_add_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout, sum} = a + b + cin, LSB-first over WIDTH cycles.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bit_s, bit_c;
  logic             last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  serial_add_cell u_cell (
    .a   (sa_q[0]),
    .b   (sb_q[0]),
    .cin (carry_q),
    .s   (bit_s),
    .c   (bit_c)
  );

  assign last = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          ps_d    = '0;
          cnt_d   = '0;
          state_d = StShift;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StShift: begin
        sa_d            = sa_q >> 1;
        sb_d            = sb_q >> 1;
        ps_d            = ps_q >> 1;
        ps_d[WIDTH-1]   = bit_s;
        carry_d         = bit_c;
        cnt_d           = cnt_q + CntW'(1);
        if (last) begin
          // Result takes the partial sum including the bit produced this cycle.
          sum_d   = ps_d;
          cout_d  = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ bit_c;
`endif
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); ovf checks when
// SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .cout  (cout),
    .ovf   (ovf)
`else
    .cout  (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and follow it to its done pulse. Optionally re-pulses
  // start with other operands while busy (repulse = cycle index, -1 for none).
  task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                       input logic [7:0] es, input logic ec, input int repulse,
                       input string tag);
    int         lat;
    int         nbusy;
    logic       stable;
    logic [7:0] old;
    old    = sum;
    stable = 1'b1;
    nbusy  = 0;
    a      = oa;
    b      = ob;
    cin    = oc;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    lat   = 0;
    @(negedge clk);
    while (!done && lat < 40) begin
      start = 1'b0;
      if (sum !== old) stable = 1'b0;
      if (busy) nbusy++;
      if (lat == repulse) begin
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h10;
        cin   = 1'b1;
      end
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'd8);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'd8);
    check({tag, "_sum_held"}, 64'(stable), 64'd1);
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
  endtask

  initial begin
    int done_seen;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_op(8'h03, 8'h05, 1'b0, 8'h08, 1'b0, -1, "add_03_05");
`ifdef SERIAL_ADDER_OVF_EN
    check("add_03_05_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_sum_held", 64'(sum), 64'h08);

    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1, "add_ff_01");
`ifdef SERIAL_ADDER_OVF_EN
    check("add_ff_01_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, -1, "add_ff_ff_c");
`ifdef SERIAL_ADDER_OVF_EN
    check("add_ff_ff_c_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, -1, "add_7f_01");
`ifdef SERIAL_ADDER_OVF_EN
    check("add_7f_01_ovf", 64'(ovf), 64'd1);
`endif
    @(negedge clk);
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, -1, "add_80_80");
`ifdef SERIAL_ADDER_OVF_EN
    check("add_80_80_ovf", 64'(ovf), 64'd1);
`endif
    @(negedge clk);

    // Second start lands while busy and must not disturb the first operation.
    do_op(8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 3, "ignore_start");
`ifdef SERIAL_ADDER_OVF_EN
    check("ignore_start_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);

    // Back-to-back: second start issued in the done cycle of the first.
    do_op(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, -1, "b2b_first");
    do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, -1, "b2b_second");
`ifdef SERIAL_ADDER_OVF_EN
    check("b2b_second_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);

    // Reset mid-SHIFT clears everything at once and suppresses done.
    a     = 8'h0F;
    b     = 8'hF0;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_sum", 64'(sum), 64'd0);
    check("mid_rst_cout", 64'(cout), 64'd0);
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    do_op(8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, -1, "after_rst");
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
